// File: rtl/div_radix.sv
// div_radix: multi-cycle restoring integer divider retiring RADIX_BITS
// quotient bits per CALC cycle, with valid/ready handshakes on both sides.
//
// Optional feature macro: DIV_RADIX_SIGNED_EN
//   defined   -> signed_op honoured (two's-complement, truncation toward zero)
//   undefined -> every operation is unsigned; signed_op is ignored
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   in_valid     operands valid
//   in_ready     divider idle, operands accepted when in_valid is high
//   signed_op    1 = signed division (only with DIV_RADIX_SIGNED_EN)
//   dividend     numerator
//   divisor      denominator
//   out_valid    result valid (held until out_ready)
//   out_ready    consumer accepts result
//   quotient     result quotient
//   remainder    result remainder
//   div_by_zero  result was produced with divisor == 0
//
// Latency: out_valid is first high in the (N+2)th cycle counting the accept
// edge as the start of cycle 1 (N = DATA_W/RADIX_BITS CALC cycles + 1 FIX).

module div_radix #(
  parameter int DATA_W     = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int N     = DATA_W / RADIX_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] quo_q;       // dividend magnitude shifting out, quotient shifting in
  logic [DATA_W-1:0] rem_q;       // partial remainder
  logic [DATA_W-1:0] dsr_q;       // divisor magnitude
  logic [DATA_W-1:0] dvd_orig_q;  // original dividend, returned on divide-by-zero
  logic [DATA_W-1:0] quotient_q;
  logic [DATA_W-1:0] remainder_q;
  logic              dz_q;

  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dsr_mag;
  logic [DATA_W-1:0] step_quo;
  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] fix_quo;
  logic [DATA_W-1:0] fix_rem;

`ifdef DIV_RADIX_SIGNED_EN
  logic qneg_q;  // operand signs differ
  logic rneg_q;  // dividend negative

  logic dvd_neg;
  logic dsr_neg;
  assign dvd_neg = signed_op & dividend[DATA_W-1];
  assign dsr_neg = signed_op & divisor[DATA_W-1];
  assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dsr_mag = dsr_neg ? (~divisor + 1'b1) : divisor;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign dvd_mag = dividend;
  assign dsr_mag = divisor;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // RADIX_BITS chained restoring steps. The trial difference is DATA_W+1 bits;
  // since the running remainder is always below the divisor, its MSB is a
  // reliable borrow flag.
  // ---------------------------------------------------------------------------
  always_comb begin : step_blk
    logic [DATA_W:0] tmp;
    logic [DATA_W:0] diff;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    tmp  = '0;
    diff = '0;
    q    = quo_q;
    r    = rem_q;
    for (int unsigned i = 0; i < RADIX_BITS; i++) begin
      tmp  = {r, q[DATA_W-1]};
      diff = tmp - {1'b0, dsr_q};
      q    = {q[DATA_W-2:0], ~diff[DATA_W]};
      r    = diff[DATA_W] ? tmp[DATA_W-1:0] : diff[DATA_W-1:0];
    end
    step_quo = q;
    step_rem = r;
  end

  // Sign fix-up and divide-by-zero override applied in FIX
  always_comb begin
`ifdef DIV_RADIX_SIGNED_EN
    fix_quo = qneg_q ? (~quo_q + 1'b1) : quo_q;
    fix_rem = rneg_q ? (~rem_q + 1'b1) : rem_q;
`else
    fix_quo = quo_q;
    fix_rem = rem_q;
`endif
    if (dsr_q == '0) begin
      fix_quo = '1;
      fix_rem = dvd_orig_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      dvd_orig_q  <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
`ifdef DIV_RADIX_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            quo_q      <= dvd_mag;
            dsr_q      <= dsr_mag;
            dvd_orig_q <= dividend;
            rem_q      <= '0;
            cnt_q      <= '0;
`ifdef DIV_RADIX_SIGNED_EN
            qneg_q     <= dvd_neg ^ dsr_neg;
            rneg_q     <= dvd_neg;
`endif
          end
        end
        CALC: begin
          quo_q <= step_quo;
          rem_q <= step_rem;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: begin
          quotient_q  <= fix_quo;
          remainder_q <= fix_rem;
          dz_q        <= (dsr_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div_radix.sv
// Self-checking bench for div_radix (DATA_W=32, RADIX_BITS=2).
// A transaction-level model (arithmetic result + fixed latency) is compared
// against the DUT every falling clock edge; directed vectors add literal
// expectations and latency measurements.

module tb_div_radix;

  localparam int W   = 32;
  localparam int RB  = 2;
  localparam int N   = W / RB;
  localparam int LAT = N + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_radix #(.DATA_W(W), .RADIX_BITS(RB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result {div_by_zero, quotient, remainder} from plain arithmetic
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    longint sa, sb, sq, sr;
    if (b == '0) begin
      return {1'b1, {W{1'b1}}, a};
    end
`ifdef DIV_RADIX_SIGNED_EN
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
      return {1'b0, q, r};
    end
`else
    sa = 0; sb = 0; sq = 0; sr = 0;
    if (s) q = '0;
`endif
    q = a / b;
    r = a % b;
    return {1'b0, q, r};
  endfunction

  // Transaction-level model: idle / busy for LAT edges / done until out_ready
  int           m_phase = 0;
  int           m_cnt = 0;
  logic [2*W:0] m_pend = '0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic         m_dz = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_q     <= '0;
      m_r     <= '0;
      m_dz    <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase <= 1;
          m_cnt   <= 1;
          m_pend  <= ref_div(dividend, divisor, signed_op);
        end
        1: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == LAT) begin
            m_phase <= 2;
            m_dz    <= m_pend[2*W];
            m_q     <= m_pend[2*W-1:W];
            m_r     <= m_pend[W-1:0];
          end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Cycle compare process
  always @(negedge clk) begin
    check("cyc_in_ready",  96'(in_ready),    96'(m_phase == 0));
    check("cyc_out_valid", 96'(out_valid),   96'(m_phase == 2));
    check("cyc_quotient",  96'(quotient),    96'(m_q));
    check("cyc_remainder", 96'(remainder),   96'(m_r));
    check("cyc_dz",        96'(div_by_zero), 96'(m_dz));
  end

  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_ready_timeout"}, 96'(in_ready), 96'(1));
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] eq,
                             input logic [W-1:0] er, input logic edz);
    int edges;
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check({name, "_latency"}, 96'(edges), 96'(LAT));
    check({name, "_q"},  96'(quotient),    96'(eq));
    check({name, "_r"},  96'(remainder),   96'(er));
    check({name, "_dz"}, 96'(div_by_zero), 96'(edz));
  endtask

  task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz);
    wait_ready(name);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    wait_result(name, eq, er, edz);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // model pins
    check("model_100_7",  96'(ref_div(32'd100, 32'd7, 1'b0)),  96'({1'b0, 32'd14, 32'd2}));
    check("model_5_0",    96'(ref_div(32'd5, 32'd0, 1'b1)),     96'({1'b1, 32'hFFFFFFFF, 32'd5}));
    check("model_1000_10", 96'(ref_div(32'd1000, 32'd10, 1'b0)), 96'({1'b0, 32'd100, 32'd0}));
`ifdef DIV_RADIX_SIGNED_EN
    check("model_ovf", 96'(ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1)),
          96'({1'b0, 32'h80000000, 32'd0}));
`else
    check("model_ovf", 96'(ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1)),
          96'({1'b0, 32'd0, 32'h80000000}));
`endif

    #2 rst = 1'b0;
    #20 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready",  96'(in_ready),    96'(1));
    check("rst_out_valid", 96'(out_valid),   96'(0));
    check("rst_quotient",  96'(quotient),    96'(0));
    check("rst_remainder", 96'(remainder),   96'(0));
    check("rst_dz",        96'(div_by_zero), 96'(0));

    run_vec("u_100_7",    32'd100,        32'd7,          1'b0, 32'd14,        32'd2,        1'b0);
`ifdef DIV_RADIX_SIGNED_EN
    run_vec("s_m7_2",     32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0);
    run_vec("s_7_m2",     32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,  32'd1,        1'b0);
    run_vec("s_ovf",      32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,  32'd0,        1'b0);
    run_vec("s_m100_m7",  32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,        32'hFFFFFFFE, 1'b0);
`else
    run_vec("s_m7_2",     32'hFFFFFFF9,   32'd2,          1'b1, 32'h7FFFFFFC,  32'd1,        1'b0);
    run_vec("s_7_m2",     32'd7,          32'hFFFFFFFE,   1'b1, 32'd0,         32'd7,        1'b0);
    run_vec("s_ovf",      32'h80000000,   32'hFFFFFFFF,   1'b1, 32'd0,         32'h80000000, 1'b0);
    run_vec("s_m100_m7",  32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd0,         32'hFFFFFF9C, 1'b0);
`endif
    run_vec("u_5_0",      32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,  32'd5,        1'b1);
    run_vec("s_5_0",      32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,  32'd5,        1'b1);
    run_vec("s_m5_0",     32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,  32'hFFFFFFFB, 1'b1);
    run_vec("u_max_1",    32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,  32'd0,        1'b0);
    run_vec("u_3_5",      32'd3,          32'd5,          1'b0, 32'd0,         32'd3,        1'b0);
    run_vec("u_dead_16",  32'hDEADBEEF,   32'h10,         1'b0, 32'h0DEADBEE,  32'hF,        1'b0);
    run_vec("u_ovf_pat",  32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,         32'h80000000, 1'b0);

    // Backpressure: result held while in_valid toggles operands
    wait_ready("bp");
    dividend = 32'd1234; divisor = 32'd10; signed_op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp_first", 32'd123, 32'd4, 1'b0);
    for (int k = 0; k < 5; k++) begin
      dividend = 32'(k * 11 + 7);
      divisor  = 32'(k + 3);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready",  96'(in_ready),  96'(0));
      check("bp_out_valid", 96'(out_valid), 96'(1));
      check("bp_q_stable",  96'(quotient),  96'(123));
      check("bp_r_stable",  96'(remainder), 96'(4));
    end
    dividend = 32'd50; divisor = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready",  96'(in_ready),  96'(1));
    check("bp_release_out_valid", 96'(out_valid), 96'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept", 96'(in_ready), 96'(0));
    wait_result("bp_second", 32'd10, 32'd0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of CALC
    wait_ready("rstmid");
    dividend = 32'd77777; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("rstmid_in_ready",  96'(in_ready),    96'(1));
    check("rstmid_out_valid", 96'(out_valid),   96'(0));
    check("rstmid_quotient",  96'(quotient),    96'(0));
    check("rstmid_remainder", 96'(remainder),   96'(0));
    check("rstmid_dz",        96'(div_by_zero), 96'(0));
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    run_vec("after_rst_1000_10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
